// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared constants, types and states for the I/O bus fabric
package io_bus_pkg;

    localparam int ID_W   = 11;
    localparam int OFS_W  = 4;
    localparam int DATA_W = 16;

    localparam logic [ID_W-1:0] ID_SIMPLE_IO = 11'h7FF;
    localparam logic [ID_W-1:0] ID_UART      = 11'h7FE;
    localparam logic [ID_W-1:0] ID_VGA       = 11'h7FD;
    localparam logic [ID_W-1:0] ID_ROM       = 11'h7FC;
    localparam logic [ID_W-1:0] ID_AUDIO     = 11'h7FB;
    localparam logic [ID_W-1:0] ID_KEYBOARD  = 11'h7FA;

    // Slot 0 sits in the least significant 11 bits.
    localparam logic [8*ID_W-1:0] DEFAULT_DEV_ID = {
        11'h7F8, 11'h7F9, ID_KEYBOARD, ID_AUDIO,
        ID_ROM, ID_VGA, ID_UART, ID_SIMPLE_IO
    };

    typedef enum logic [1:0] {
        IDLE,
        HAZ,
        ACC,
        WAIT
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              rd;
        logic              wr;
        logic              io_space;
        logic [ID_W-1:0]   id;
        logic [OFS_W-1:0]  offset;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/io_addr_decoder.sv
// rtl/io_addr_decoder.sv - combinational device-ID match producing a one-hot slot select
module io_addr_decoder
    import io_bus_pkg::*;
#(
    parameter int                       NUM_DEV = 8,
    parameter logic [NUM_DEV*ID_W-1:0]  DEV_ID  = DEFAULT_DEV_ID
) (
    input  logic [ID_W-1:0]    id_i,
    output logic [NUM_DEV-1:0] select_o,
    output logic               hit_o
);

    // Scanning downwards lets the lowest matching slot overwrite any higher one.
    always_comb begin
        select_o = '0;
        hit_o    = 1'b0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (id_i == DEV_ID[i*ID_W +: ID_W]) begin
                select_o    = '0;
                select_o[i] = 1'b1;
                hit_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_bus_fabric.sv
// rtl/io_bus_fabric.sv - Stage 2/3 I/O fabric with wait states, timeout, RAW interlock and error count
module io_bus_fabric
    import io_bus_pkg::*;
#(
    parameter int                       NUM_DEV       = 8,
    parameter logic [NUM_DEV*ID_W-1:0]  DEV_ID        = DEFAULT_DEV_ID,
    parameter int                       TIMEOUT       = 15,
    parameter logic [DATA_W-1:0]        UNMAPPED_DATA = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      clk_en,
    input  logic                      reset,
    input  logic [15:0]               io_addr,
    input  logic [DATA_W-1:0]         io_wdata,
    input  logic                      io_read_req,
    input  logic                      io_write_req,
    output logic                      io_stall,
    output logic [DATA_W-1:0]         io_rdata,
    output logic                      io_err,
    output logic [15:0]               err_count,
    output logic [NUM_DEV-1:0]        dev_select,
    output logic [OFS_W-1:0]          dev_offset,
    output logic                      dev_read_req,
    output logic                      dev_write_req,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]        dev_ready
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_e            state_q, state_d;
    req_t              r_q, r_d;
    logic [7:0]        wait_q, wait_d;
    logic [15:0]       err_q, err_d;

    logic [NUM_DEV-1:0] sel;
    logic               dec_hit;
    logic               hit;
    logic [DATA_W-1:0]  sel_rdata;
    logic               sel_ready;
    logic               busy, timed_out, miss, complete, acc_err, stall;
    logic               strobe_en, new_rd, new_valid, raw_haz;

    io_addr_decoder #(
        .NUM_DEV (NUM_DEV),
        .DEV_ID  (DEV_ID)
    ) u_dec (
        .id_i     (r_q.id),
        .select_o (sel),
        .hit_o    (dec_hit)
    );

    // An address outside I/O space can never reach a device.
    assign hit = dec_hit && r_q.io_space;

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel[i]) begin
                sel_rdata = sel_rdata | dev_rdata[i*DATA_W +: DATA_W];
                sel_ready = sel_ready | dev_ready[i];
            end
        end
    end

    always_comb begin
        busy      = r_q.valid && (state_q == ACC || state_q == WAIT);
        miss      = busy && !hit;
        timed_out = busy && hit && !sel_ready && (state_q == WAIT) && (wait_q == TO_CNT);
        complete  = busy && (!hit || sel_ready || timed_out);
        acc_err   = miss || timed_out;
        stall     = (state_q == HAZ) || (busy && !complete);
    end

    // Outputs are forced low while reset is asserted so an aborted write never commits.
    always_comb begin
        strobe_en     = busy && hit && !reset;
        dev_select    = strobe_en ? sel : '0;
        dev_read_req  = strobe_en && r_q.rd;
        dev_write_req = strobe_en && r_q.wr;
        dev_offset    = strobe_en ? r_q.offset : '0;
        dev_wdata     = (strobe_en && r_q.wr) ? r_q.wdata : '0;
        io_stall      = stall && !reset;
        io_err        = acc_err && !reset;
        io_rdata      = '0;
        if (!reset && complete && r_q.rd) begin
            io_rdata = acc_err ? UNMAPPED_DATA : sel_rdata;
        end
        err_count     = reset ? '0 : err_q;
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        wait_d    = wait_q;
        err_d     = err_q;
        new_valid = io_read_req || io_write_req;
        new_rd    = io_read_req && !io_write_req;
        raw_haz   = new_rd && complete && r_q.wr && hit && io_addr[15]
                    && (io_addr[14:4] == r_q.id);

        if (acc_err && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end

        if (!stall) begin
            r_d.valid    = new_valid;
            r_d.rd       = new_rd;
            r_d.wr       = io_write_req;
            r_d.io_space = io_addr[15];
            r_d.id       = io_addr[14:4];
            r_d.offset   = io_addr[3:0];
            r_d.wdata    = io_wdata;
            wait_d       = 8'd0;
            if (!new_valid) begin
                state_d = IDLE;
            end else if (raw_haz) begin
                state_d = HAZ;
            end else begin
                state_d = ACC;
            end
        end else begin
            case (state_q)
                HAZ:     state_d = ACC;
                ACC: begin
                    state_d = WAIT;
                    wait_d  = 8'd1;
                end
                WAIT:    wait_d = wait_q + 8'd1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (reset) begin
                state_q <= IDLE;
                r_q     <= '0;
                wait_q  <= 8'd0;
                err_q   <= 16'd0;
            end else begin
                state_q <= state_d;
                r_q     <= r_d;
                wait_q  <= wait_d;
                err_q   <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_fabric.sv
// tb/tb_io_bus_fabric.sv - directed self-checking bench for io_bus_fabric
module tb_io_bus_fabric;
    import io_bus_pkg::*;

    logic         clk = 1'b0;
    logic         clk_en;
    logic         reset;
    logic [15:0]  io_addr;
    logic [15:0]  io_wdata;
    logic         io_read_req;
    logic         io_write_req;
    logic         io_stall;
    logic [15:0]  io_rdata;
    logic         io_err;
    logic [15:0]  err_count;
    logic [7:0]   dev_select;
    logic [3:0]   dev_offset;
    logic         dev_read_req;
    logic         dev_write_req;
    logic [15:0]  dev_wdata;
    logic [127:0] dev_rdata;
    logic [7:0]   dev_ready;

    int vectors     = 0;
    int miscompares = 0;
    int commits     = 0;

    io_bus_fabric #(
        .NUM_DEV (8),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .clk_en        (clk_en),
        .reset         (reset),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_read_req   (io_read_req),
        .io_write_req  (io_write_req),
        .io_stall      (io_stall),
        .io_rdata      (io_rdata),
        .io_err        (io_err),
        .err_count     (err_count),
        .dev_select    (dev_select),
        .dev_offset    (dev_offset),
        .dev_read_req  (dev_read_req),
        .dev_write_req (dev_write_req),
        .dev_wdata     (dev_wdata),
        .dev_rdata     (dev_rdata),
        .dev_ready     (dev_ready)
    );

    always #5 clk = ~clk;

    // Device-side view of a committed write.
    always @(posedge clk) begin
        if (clk_en && dev_write_req && ((dev_select & dev_ready) != 8'h00)) begin
            commits++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        clk_en       = 1'b1;
        reset        = 1'b1;
        io_addr      = 16'h0000;
        io_wdata     = 16'h0000;
        io_read_req  = 1'b0;
        io_write_req = 1'b0;
        dev_ready    = 8'hFF;
        dev_rdata    = '0;
        dev_rdata[15:0]  = 16'h1234;
        dev_rdata[31:16] = 16'hABCD;
        dev_rdata[47:32] = 16'h5555;

        cyc();
        cyc();
        io_read_req = 1'b1;
        io_addr     = 16'hFFF2;
        settle();
        chk("rst_stall", 32'(io_stall), 0);
        chk("rst_rdata", 32'(io_rdata), 0);
        chk("rst_err", 32'(io_err), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        chk("rst_sel", 32'(dev_select), 0);
        chk("rst_rreq", 32'(dev_read_req), 0);
        chk("rst_ofs", 32'(dev_offset), 0);
        cyc();
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));

        // Zero-wait read of slot 0
        reset = 1'b0;
        settle();
        chk("zw_stall_req", 32'(io_stall), 0);
        cyc();
        io_read_req = 1'b0;
        settle();
        chk("zw_stall", 32'(io_stall), 0);
        chk("zw_ofs", 32'(dev_offset), 2);
        chk("zw_sel", 32'(dev_select), 'h01);
        chk("zw_rreq", 32'(dev_read_req), 1);
        chk("zw_rdata", 32'(io_rdata), 'h1234);
        chk("zw_err", 32'(io_err), 0);
        cyc();
        settle();
        chk("zw_idle_rdata", 32'(io_rdata), 0);
        chk("zw_idle_rreq", 32'(dev_read_req), 0);

        // Slot 1 ready only on the fourth Stage 3 cycle
        dev_ready[1] = 1'b0;
        io_read_req  = 1'b1;
        io_addr      = 16'hFFE0;
        settle();
        cyc();
        io_read_req = 1'b0;
        settle();
        for (int k = 0; k < 3; k++) begin
            chk("ws_stall", 32'(io_stall), 1);
            chk("ws_rreq", 32'(dev_read_req), 1);
            chk("ws_sel", 32'(dev_select), 'h02);
            cyc();
            if (k == 2) dev_ready[1] = 1'b1;
            settle();
        end
        chk("ws_done_stall", 32'(io_stall), 0);
        chk("ws_rdata", 32'(io_rdata), 'hABCD);
        chk("ws_rreq_held", 32'(dev_read_req), 1);
        cyc();
        settle();

        // Unmapped read
        io_read_req = 1'b1;
        io_addr     = 16'h8000;
        settle();
        cyc();
        io_read_req = 1'b0;
        settle();
        chk("um_stall", 32'(io_stall), 0);
        chk("um_rdata", 32'(io_rdata), 'hFFFF);
        chk("um_err", 32'(io_err), 1);
        chk("um_rreq", 32'(dev_read_req), 0);
        chk("um_sel", 32'(dev_select), 0);
        cyc();
        settle();
        chk("um_cnt", 32'(err_count), 1);
        chk("um_err_clr", 32'(io_err), 0);

        // Timed-out write to slot 2 with a clock-enable freeze mid-WAIT
        dev_ready[2] = 1'b0;
        io_write_req = 1'b1;
        io_addr      = 16'hFFD0;
        io_wdata     = 16'hBEEF;
        settle();
        cyc();
        io_write_req = 1'b0;
        settle();
        chk("to_stall_acc", 32'(io_stall), 1);
        chk("to_wreq", 32'(dev_write_req), 1);
        chk("to_wdata", 32'(dev_wdata), 'hBEEF);
        chk("to_sel", 32'(dev_select), 'h04);
        cyc();
        settle();
        chk("to_stall_w1", 32'(io_stall), 1);
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 4) clk_en = 1'b1;
            settle();
            chk("to_frz_stall", 32'(io_stall), 1);
            chk("to_frz_err", 32'(io_err), 0);
        end
        cyc();
        settle();
        chk("to_stall_w2", 32'(io_stall), 1);
        cyc();
        settle();
        chk("to_stall_w3", 32'(io_stall), 1);
        cyc();
        settle();
        chk("to_done_stall", 32'(io_stall), 0);
        chk("to_err", 32'(io_err), 1);
        chk("to_rdata", 32'(io_rdata), 0);
        cyc();
        settle();
        chk("to_cnt", 32'(err_count), 2);
        chk("to_commits", 32'(commits), 0);

        // RAW interlock: write then read of the same slot
        dev_ready    = 8'hFF;
        io_write_req = 1'b1;
        io_addr      = 16'hFFF0;
        io_wdata     = 16'h00A5;
        settle();
        cyc();
        io_write_req = 1'b0;
        io_read_req  = 1'b1;
        io_addr      = 16'hFFF0;
        settle();
        chk("raw_w_stall", 32'(io_stall), 0);
        chk("raw_wreq", 32'(dev_write_req), 1);
        cyc();
        io_read_req = 1'b0;
        settle();
        chk("raw_haz_stall", 32'(io_stall), 1);
        chk("raw_haz_rreq", 32'(dev_read_req), 0);
        cyc();
        settle();
        chk("raw_rd_stall", 32'(io_stall), 0);
        chk("raw_rdata", 32'(io_rdata), 'h1234);
        chk("raw_rreq", 32'(dev_read_req), 1);
        cyc();
        settle();
        chk("raw_commits", 32'(commits), 1);

        // Write slot 0 then read slot 1: no interlock
        io_write_req = 1'b1;
        io_addr      = 16'hFFF0;
        io_wdata     = 16'h1111;
        settle();
        cyc();
        io_write_req = 1'b0;
        io_read_req  = 1'b1;
        io_addr      = 16'hFFE0;
        settle();
        chk("nr_w_stall", 32'(io_stall), 0);
        cyc();
        io_read_req = 1'b0;
        settle();
        chk("nr_stall", 32'(io_stall), 0);
        chk("nr_rdata", 32'(io_rdata), 'hABCD);
        chk("nr_sel", 32'(dev_select), 'h02);
        cyc();
        settle();
        chk("nr_commits", 32'(commits), 2);

        // Reset during WAIT, with the device becoming ready in the reset cycle
        dev_ready[1] = 1'b0;
        io_write_req = 1'b1;
        io_addr      = 16'hFFE4;
        io_wdata     = 16'h7777;
        settle();
        cyc();
        io_write_req = 1'b0;
        settle();
        chk("rw_stall_acc", 32'(io_stall), 1);
        cyc();
        settle();
        chk("rw_stall_wait", 32'(io_stall), 1);
        reset        = 1'b1;
        dev_ready[1] = 1'b1;
        settle();
        chk("rw_rst_stall", 32'(io_stall), 0);
        chk("rw_rst_wreq", 32'(dev_write_req), 0);
        chk("rw_rst_sel", 32'(dev_select), 0);
        chk("rw_rst_wdata", 32'(dev_wdata), 0);
        chk("rw_rst_cnt", 32'(err_count), 0);
        cyc();
        settle();
        chk("rw_state", 32'(dut.state_q), 32'(IDLE));
        chk("rw_commits", 32'(commits), 2);
        reset = 1'b0;
        settle();
        chk("rw_cnt_after", 32'(err_count), 0);
        chk("rw_stall_after", 32'(io_stall), 0);
        cyc();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_bus_fabric.md
# io_bus_fabric

Parametrised successor to the fixed six-device I/O decoder. It sits between the core's Stage 2/3 memory path (addresses with bit 15 set) and up to NUM_DEV device controllers. It adds per-device wait states through a `dev_ready` handshake, a core stall output, a bus timeout, an automatic read-after-write interlock and an error counter. With every device permanently ready, it reproduces the legacy 1-cycle request-to-data latency.

## Interface
- `NUM_DEV`, 8: number of device slots (1..32).
- `DEV_ID`, {7FF,7FE,7FD,7FC,7FB,7FA,7F9,7F8}: packed `NUM_DEV*11` bits; slot i responds to `io_addr[14:4] == DEV_ID[i]`.
- `TIMEOUT`, 15: maximum wait cycles before forced completion (1..255).
- `UNMAPPED_DATA`, 16'hFFFF: read data returned on unmapped access or timeout.
- `clk` in 1: system clock. Single clock domain.
- `clk_en` in 1: global clock enable. All state advances only when it is 1.
- `reset` in 1: synchronous, active-high. Sampled on `clk` edges with `clk_en`=1.
- `io_addr` in 16: Stage 2 address.
- `io_wdata` in 16: Stage 2 write data.
- `io_read_req` in 1: Stage 2 load to I/O space.
- `io_write_req` in 1: Stage 2 store to I/O space.
- `io_stall` out 1: core must freeze its pipeline and hold its Stage 2 inputs.
- `io_rdata` out 16: Stage 3 read data.
- `io_err` out 1: the completing access was unmapped or timed out.
- `err_count` out 16: saturating count of error completions.
- `dev_select` out NUM_DEV: one-hot device select.
- `dev_offset` out 4: register offset.
- `dev_read_req` out 1: read strobe to devices.
- `dev_write_req` out 1: write strobe to devices.
- `dev_wdata` out 16: write data to devices.
- `dev_rdata` in NUM_DEV*16: per-slot read data, slot i at [16i+15:16i].
- `dev_ready` in NUM_DEV: per-slot completion. Fixed-latency devices tie it to 1.

## Operation
- **Capture.** The Stage register R captures {valid, rd, wr, id, offset, wdata} when `clk_en` is 1 and `io_stall` is 0. Valid is set by `rd|wr`. If both `rd` and `wr` are set, it is treated as a write.
- **Decode.** R.id is compared against all DEV_ID entries. On duplicate IDs the lowest index wins. No match is a miss.
- **States:**
  - IDLE: R is not valid.
  - HAZ: one-cycle RAW interlock.
  - ACC: first access cycle.
  - WAIT: device not yet ready.
- **Into HAZ.** A read enters HAZ if the transaction that completed on the previous enabled cycle was a write to the same slot. Otherwise a read or write enters ACC.
- **HAZ.** `dev_read_req`=0, `io_stall`=1, next state is ACC.
- **ACC and WAIT strobes.** `dev_select`, `dev_read_req` and `dev_write_req` are driven from R, and held for as long as the access is pending.
- **Completion on ready.** The access completes when the selected `dev_ready` is 1: `io_stall`=0, and for reads `io_rdata` = the selected slice. A device commits a write only on a cycle where `dev_write_req`, its select and `dev_ready` are all 1. It commits exactly once.
- **Not ready.** If the device is not ready in ACC: `io_stall`=1, `wait_cnt`=1, next state is WAIT.
- **WAIT.** On ready, complete. Otherwise, if `wait_cnt`==TIMEOUT, force completion: `io_rdata`=UNMAPPED_DATA, `io_err`=1, no write is committed. Otherwise increment `wait_cnt`.
- **Miss.** A miss completes in ACC with `io_rdata`=UNMAPPED_DATA, `io_err`=1 and no strobes.
- **After completion.** The next request is captured on the same edge, back-to-back.
- **Idle outputs.** When no read is completing, `io_rdata` is 16'h0000 (no X).
- **Error counter.** `err_count` increments by 1 per error completion and saturates at 16'hFFFF.

## Timing
- **Reset.** State IDLE, R invalid, `wait_cnt`=0, and every output is 0: `io_stall`, `io_rdata`, `io_err`, `err_count`, `dev_*`. Reset mid-WAIT aborts the access. No write is committed in that cycle.
- **Zero-wait latency.** Request presented in enabled cycle N gives data or write commit in N+1.
- **Interlock latency.** A RAW pair costs 1 stall cycle, so read data arrives in N+2.
- **Timeout latency.** Worst case is TIMEOUT+1 cycles in Stage 3.
- **Combinational paths.** `io_stall` and `io_rdata` are combinational from R, state and `dev_ready`/`dev_rdata`. No path runs from `io_addr` to any output.
- **Clock enable low.** All state holds and outputs are stable.

## Structure
- Package `io_bus_pkg` holds:
  - device-ID constants: SIMPLE_IO 7FF, UART 7FE, VGA 7FD, ROM 7FC, AUDIO 7FB, KEYBOARD 7FA;
  - field widths: ID 11, offset 4, data 16;
  - the state enum {IDLE, HAZ, ACC, WAIT}.
- Sub-module `io_addr_decoder` is combinational and parametrised by NUM_DEV and DEV_ID. It takes id and produces the one-hot select and hit, with the lowest index winning.

## Test plan
- **Zero-wait read.** All ready=1, slot0 rdata=16'h1234, read 0xFFF2 → `dev_offset`=2, `io_rdata`=16'h1234 next cycle, `io_stall` never 1.
- **Wait states.** Slot1 ready after 3 cycles, read 0xFFE0 → `io_stall`=1 for 3 cycles, data on the 4th, strobe held throughout.
- **Timeout.** TIMEOUT=4, slot2 never ready, write 0xFFD0 → `io_stall`=1 for 4 cycles, `io_err` pulse, `err_count`=1, no committed write.
- **Unmapped read.** Read 0x8000 → `io_rdata`=16'hFFFF, `io_err`=1, 0 stall cycles.
- **RAW interlock.** Write 0xFFF0 then read 0xFFF0 back-to-back → one HAZ stall with `dev_read_req`=0, then a correct read. Write slot0 then read slot1 → no stall.
- **Reset and clock enable.** Reset asserted in WAIT → all outputs 0 and state IDLE. `clk_en`=0 for 5 cycles mid-WAIT → `wait_cnt` frozen.
